// File: rtl/alu_serial_core_if.sv
// Byte-serial ALU core handshake bundle.
// Input byte channel, output byte channel and status.
interface alu_serial_core_if;
  logic [7:0] in_byte;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] flags;
  logic       busy;

  modport slave (
    input  in_byte, in_valid, op, out_ready,
    output in_ready, out_byte, out_valid, flags, busy
  );

  modport master (
    output in_byte, in_valid, op, out_ready,
    input  in_ready, out_byte, out_valid, flags, busy
  );
endinterface

// File: rtl/alu_serial_core.sv
// Byte-serial integer ALU: loads A then B LSB-first,
// executes one op, streams the result back out.
module alu_serial_core #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  alu_serial_core_if.slave bus
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int SW = $clog2(WIDTH);
  localparam int M  = WIDTH - 1;

  typedef enum logic [1:0] {
    LOAD_A, LOAD_B, EXEC, SEND
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_r;
  logic [2:0]       r_op;
  logic [3:0]       r_flags;

  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SW-1:0]    w_sh;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  assign w_last = (r_cnt == CW'(NB - 1));
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = r_a - r_b;
  assign w_sh   = r_b[SW-1:0];

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (r_op)
      3'b000: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_a[M] == r_b[M]) &&
                (w_sum[M] != r_a[M]);
      end
      3'b001: begin
        w_res = w_diff;
        w_c   = (r_a >= r_b);
        w_v   = (r_a[M] != r_b[M]) &&
                (w_diff[M] != r_a[M]);
      end
      3'b010: w_res = r_a & r_b;
      3'b011: w_res = r_a | r_b;
      3'b100: w_res = r_a ^ r_b;
      3'b101: w_res = r_a << w_sh;
      3'b110: w_res = r_a >> w_sh;
      3'b111: w_res = {{(WIDTH-1){1'b0}},
                       $signed(r_a) < $signed(r_b)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_r     <= '0;
      r_op    <= '0;
      r_flags <= '0;
    end else if (ena) begin
      unique case (r_state)
        LOAD_A: if (bus.in_valid) begin
          r_a[{r_cnt, 3'b000} +: 8] <= bus.in_byte;
          if (r_cnt == '0) r_op <= bus.op;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= LOAD_B;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        LOAD_B: if (bus.in_valid) begin
          r_b[{r_cnt, 3'b000} +: 8] <= bus.in_byte;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= EXEC;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        EXEC: begin
          r_r     <= w_res;
          r_flags <= {w_v, w_res[M], w_c, w_res == '0};
          r_cnt   <= '0;
          r_state <= SEND;
        end
        SEND: if (bus.out_ready) begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= LOAD_A;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  // Handshakes are pure decodes so a low ena drops them the same cycle.
  assign bus.in_ready  = ena && (r_state == LOAD_A ||
                                 r_state == LOAD_B);
  assign bus.out_valid = ena && (r_state == SEND);
  assign bus.out_byte  = (r_state == SEND) ?
                         r_r[{r_cnt, 3'b000} +: 8] : 8'h00;
  assign bus.flags     = r_flags;
  assign bus.busy      = !(r_state == LOAD_A && r_cnt == '0);

endmodule

// File: tb/tb_alu_serial_core.sv
// Scoreboard bench for alu_serial_core: directed cases,
// stalls, reset abort and randomized ops vs a reference model.
module tb_alu_serial_core;

  localparam int W  = 32;
  localparam int NB = W / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic ena8 = 1'b1;

  always #5 clk = ~clk;

  alu_serial_core_if bus();
  alu_serial_core_if b8();

  alu_serial_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.slave)
  );

  alu_serial_core #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ena(ena8), .bus(b8.slave)
  );

  typedef struct {
    logic [7:0] b;
    bit         first;
    logic [3:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   manual = 1'b0;
  bit   rand_bp = 1'b0;
  bit   hold = 1'b0;
  logic [7:0] held;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on integers, width w <= 32.
  function automatic void model(
    input longint unsigned a, input longint unsigned b,
    input int op, input int w,
    output longint unsigned r, output logic [3:0] fl);
    longint unsigned mask, full;
    longint sa, sb, mx, mn, t;
    bit c, v;
    full = 64'd1 << w;
    mask = full - 1;
    sa = a[w-1] ? longint'(a) - longint'(full) : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(full) : longint'(b);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    c = 0;
    v = 0;
    case (op)
      0: begin
        r = (a + b) & mask;
        c = (a + b) >= full;
        t = sa + sb;
        v = (t > mx) || (t < mn);
      end
      1: begin
        r = (a - b) & mask;
        c = (a >= b);
        t = sa - sb;
        v = (t > mx) || (t < mn);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a << (b % w)) & mask;
      6: r = a >> (b % w);
      default: r = (sa < sb) ? 1 : 0;
    endcase
    fl = {v, r[w-1], c, r == 0};
  endfunction

  task automatic push_exp(input logic [31:0] a,
                          input logic [31:0] b,
                          input int op);
    longint unsigned r;
    logic [3:0] fl;
    model(a, b, op, W, r, fl);
    for (int i = 0; i < NB; i++)
      exp_q.push_back('{b: 8'(r >> (8 * i)),
                        first: (i == 0), fl: fl});
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] v);
    int n = 0;
    bus.in_byte  = v;
    bus.in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 500) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
  endtask

  task automatic send_txn(input logic [31:0] a,
                          input logic [31:0] b,
                          input int op,
                          input bit rgap,
                          input bit gap_a1);
    for (int i = 0; i < NB; i++) begin
      if (rgap) gap($urandom_range(0, 2));
      bus.op = (i == 0) ? 3'(op) : 3'($urandom);
      put_byte(a[8*i +: 8]);
      if (gap_a1 && i == 1) gap(2);
    end
    for (int i = 0; i < NB; i++) begin
      if (rgap) gap($urandom_range(0, 2));
      bus.op = 3'($urandom);
      if (i == NB - 1) push_exp(a, b, op);
      put_byte(b[8*i +: 8]);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) &&
           n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: pops expectations on every accepted output byte.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 1'b0;
      end else if (bus.out_valid) begin
        if (hold) begin
          check("hold_stable", bus.out_byte, held);
          hold = 1'b0;
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_out: got %0h expected none",
                     bus.out_byte);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", bus.out_byte, e.b);
            if (e.first) check("flags", bus.flags, e.fl);
          end
        end else begin
          hold = 1'b1;
          held = bus.out_byte;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!manual)
        bus.out_ready = rand_bp ?
          ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint unsigned r8;
    logic [3:0] f8;
    logic [31:0] ra, rb;
    bus.in_byte = 8'h00; bus.in_valid = 1'b0;
    bus.op = 3'd0; bus.out_ready = 1'b1;
    b8.in_byte = 8'h00; b8.in_valid = 1'b0;
    b8.op = 3'd0; b8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_byte", bus.out_byte, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_flags", bus.flags, 0);
    @(posedge clk);
    #1;

    send_txn(32'h00000001, 32'hFFFFFFFF, 0, 0, 0);
    @(negedge clk);
    check("exec_out_valid", bus.out_valid, 0);
    check("exec_busy", bus.busy, 1);
    @(negedge clk);
    check("latency_out_valid", bus.out_valid, 1);
    wait_drain();
    check("add_flags", bus.flags, 4'b0011);

    send_txn(32'h00000081, 32'h00000024, 5, 0, 1);
    wait_drain();
    send_txn(32'hFFFFFFFE, 32'h00000001, 7, 0, 0);
    wait_drain();

    manual = 1'b1;
    bus.out_ready = 1'b1;
    send_txn(32'h80000000, 32'h00000001, 1, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 ena = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("ena_out_valid", bus.out_valid, 0);
      check("ena_in_ready", bus.in_ready, 0);
      check("ena_flags", bus.flags, 4'b1010);
      check("ena_busy", bus.busy, 1);
    end
    @(posedge clk);
    #1 ena = 1'b1;
    manual = 1'b0;
    wait_drain();
    check("sub_flags", bus.flags, 4'b1010);

    bus.op = 3'd0;
    for (int i = 0; i < NB; i++) put_byte(8'h11 * 8'(i + 1));
    put_byte(8'hAA);
    put_byte(8'h55);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_byte", bus.out_byte, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_flags", bus.flags, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    send_txn(32'hF0F0F0F0, 32'hFFFF0000, 4, 0, 0);
    wait_drain();

    rand_bp = 1'b1;
    repeat (40) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      send_txn(ra, rb, $urandom_range(0, 7), 1, 0);
    end
    wait_drain();
    rand_bp = 1'b0;

    model(64'h7F, 64'h01, 0, 8, r8, f8);
    b8.op = 3'd0;
    b8.in_byte = 8'h7F;
    b8.in_valid = 1'b1;
    @(posedge clk);
    #1 b8.in_byte = 8'h01;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_exec_valid", b8.out_valid, 0);
    @(negedge clk);
    check("w8_out_valid", b8.out_valid, 1);
    check("w8_out_byte", b8.out_byte, r8);
    check("w8_out_const", b8.out_byte, 8'h80);
    check("w8_flags", b8.flags, f8);
    check("w8_flags_const", b8.flags, 4'b1100);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("w8_idle_busy", b8.busy, 0);
    check("w8_idle_flags", b8.flags, 4'b1100);
    b8.in_byte = 8'h10;
    b8.in_valid = 1'b1;
    @(posedge clk);
    #1 b8.in_valid = 1'b0;
    @(negedge clk);
    check("w8_loadb_busy", b8.busy, 1);
    check("w8_loadb_flags", b8.flags, 4'b1100);
    check("w8_loadb_valid", b8.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_serial_core.md
# alu_serial_core

Byte-serial, parametrised-width integer ALU core for the TinyTapeout top level. The top maps its 8-bit pins onto this core. Operands A and B arrive one byte at a time over a valid/ready input channel, least-significant byte first. The core executes one of eight operations, then streams the registered result out over a valid/ready output channel and holds status flags for the top to expose.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal values are multiples of 8 from 8 to 64. NB = WIDTH/8 bytes per operand.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  design enable; when low, all state is frozen and in_ready/out_valid read 0.
- in_byte  in  8  operand byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  core accepts a byte this cycle.
- op  in  3  operation code, sampled with the first byte of A.
- out_byte  out  8  result byte.
- out_valid  out  1  out_byte is valid.
- out_ready  in  1  consumer takes out_byte this cycle.
- flags  out  4  {V, N, C, Z} of the last executed operation.
- busy  out  1  high in every state except LOAD_A with byte count 0.

## Operation
- States: LOAD_A, LOAD_B, EXEC, SEND. Reset state is LOAD_A.
- Byte counter cnt has width clog2(NB), minimum 1 bit.
- Input accept = in_valid & in_ready & ena. in_ready = ena & (state is LOAD_A or LOAD_B).
- LOAD_A: an accepted byte is written to A[8*cnt +: 8].
  - If cnt is 0, op is also latched into op_r.
  - On cnt = NB-1, cnt resets to 0 and the state moves to LOAD_B; otherwise cnt increments.
- LOAD_B: same byte-loading rule into B; on cnt = NB-1 the state moves to EXEC.
- EXEC: lasts exactly one cycle. The result and flags are registered, then the state moves to SEND with cnt = 0.
- SEND: out_valid = ena and out_byte = R[8*cnt +: 8]. Outside SEND, out_byte = 0.
  - On each accepted byte (out_valid & out_ready) cnt increments.
  - After byte NB-1 is accepted, the state returns to LOAD_A with cnt = 0.
- Operations, on WIDTH-bit operands:
  - 000 ADD: R = A + B. C = carry out. V = signed overflow.
  - 001 SUB: R = A - B. C = 1 when A >= B unsigned (no borrow). V = signed overflow.
  - 010 AND, 011 OR, 100 XOR: bitwise.
  - 101 SLL: R = A << B[clog2(WIDTH)-1:0].
  - 110 SRL: logical right shift, same shift amount rule as SLL.
  - 111 SLT: R = 1 if A < B signed, else 0.
  - Operations other than ADD and SUB force C = 0 and V = 0.
- Flags for every operation: Z = (R == 0); N = R[WIDTH-1].
- Flags are updated only in EXEC and held until the next EXEC.
- ena low: state, counters, A, B, R and flags are all frozen; handshakes resume when ena returns high.
- in_valid during EXEC or SEND is ignored, and no byte is consumed.

## Timing
- Reset values: state LOAD_A, cnt 0, A/B/R/op_r 0, flags 0, out_byte 0, out_valid 0, busy 0. in_ready is 1 if ena is high.
- rst_n low at any point, including mid-load or mid-send, aborts the transaction immediately. Partially received bytes are discarded.
- in_ready, out_valid and busy are decoded combinationally from registered state and ena. out_byte is a mux of registered R.
- Latency: if the last B byte is accepted at edge k, EXEC occupies cycle k to k+1. out_valid is high with byte 0 from edge k+1.
- Minimum transaction with no stalls is 3*NB + 1 cycles.
- Backpressure: while out_valid is high and out_ready is low, out_byte is held stable and no byte is skipped or repeated.
- Input gaps (in_valid low) stall loading indefinitely without side effects.

## Test plan
- ADD, WIDTH=32: A=0x00000001, B=0xFFFFFFFF, op=000 -> bytes 00,00,00,00; flags Z=1, C=1, V=0, N=0.
- SUB: A=0x80000000, B=0x00000001, op=001 -> bytes FF,FF,FF,7F; V=1, C=1, N=0, Z=0.
- SLL: A=0x00000081, B=0x00000024, op=101 -> shift amount 4, R=0x00000810, bytes 10,08,00,00. SLT with A=0xFFFFFFFE, B=0x00000001 -> R=0x00000001.
- Stall handling:
  - Drop in_valid for 2 cycles mid-A and check nothing extra is loaded.
  - Hold out_ready low for 3 cycles on byte 1 and check out_byte is stable.
  - Drop ena for 4 cycles in SEND and check all state is frozen and out_valid=0.
  - Confirm correct bytes are delivered in every case.
- Reset handling: assert rst_n low after 2 bytes of B -> all outputs return to reset values. A following full XOR transaction, 0xF0F0F0F0 ^ 0xFFFF0000 -> bytes F0,F0,0F,0F.
- WIDTH=8 instance: A=0x7F, B=0x01, ADD -> single byte 0x80, V=1, N=1. Check flags hold their value through the following LOAD phases.
